// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge slot arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT,
        ST_RECOVER,
        ST_ERRACK
    } state_t;

    // Atari address bits [15:13] that select each cartridge window
    localparam logic [2:0] S4_HI = 3'b100;
    localparam logic [2:0] S5_HI = 3'b101;

    // Byte returned when nothing drives the cartridge bus
    localparam logic [7:0] EMPTY_BYTE = 8'hFF;

    // WAIT / RECOVER counters share one width (parameters are limited to 1..15)
    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;

    // Terminal count for a phase lasting 'cycles' clocks
    function automatic cnt_t last_count(input int cycles);
        return cnt_t'(cycles - 1);
    endfunction

endpackage

// File: rtl/cart_rr_arb.sv
// Two-way round-robin arbiter for the cartridge slot.
// Latency: grant is combinational from req; pointer moves on the edge after adv.
// Backpressure: none; requests wait (level) until the caller strobes adv.
module cart_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] grant,
    output logic       ptr
);

    // One-hot grant; the pointer only matters when both ports ask at once
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

    // After each grant, prefer the port that was not just served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (adv) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/cart_bus_arbiter.sv
// Shares the cartridge slot between CPU (port 0) and ANTIC DMA (port 1), one read at a time.
// Latency: valid read acks in cycle 2+WAIT_CYCLES after grant, error acks in cycle 1.
// Backpressure: req is a level held until ack; the losing port simply waits in IDLE.
module cart_bus_arbiter
    import cart_pkg::*;
#(
    parameter int WAIT_CYCLES    = 4,
    parameter int RECOVER_CYCLES = 1,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    output logic [1:0]  ack,
    output logic        err,
    output logic [7:0]  rd_data,
    output logic        busy,
    input  logic        rd4,
    input  logic        rd5,
    output logic [12:0] cart_addr,
    output logic        s4_n,
    output logic        s5_n,
    input  logic [7:0]  cart_data
);

    localparam cnt_t WAIT_LAST = last_count(WAIT_CYCLES);
    localparam cnt_t REC_LAST  = last_count(RECOVER_CYCLES);

    state_t      state, state_nxt;
    cnt_t        cnt, cnt_nxt;
    logic        gnt_port, gnt_port_nxt;
    logic [1:0]  ack_nxt;
    logic        err_nxt;
    logic [7:0]  rd_data_nxt;
    logic [12:0] cart_addr_nxt;
    logic        s4_n_nxt, s5_n_nxt;
    logic        busy_nxt;

    logic [SYNC_STAGES-1:0] rd4_sync, rd5_sync;
    logic                   rd4_ok, rd5_ok;

    logic [1:0]  arb_grant;
    logic        arb_ptr;
    logic        arb_adv;
    logic        gnt_idx;
    logic [15:0] sel_addr;

    assign rd4_ok = rd4_sync[SYNC_STAGES-1];
    assign rd5_ok = rd5_sync[SYNC_STAGES-1];

    // On a tie the pointer is the winner; otherwise the lone requester wins
    assign gnt_idx  = (req == 2'b11) ? arb_ptr : arb_grant[1];
    assign sel_addr = arb_grant[0] ? addr0 : addr1;

    cart_rr_arb u_rr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .adv   (arb_adv),
        .grant (arb_grant),
        .ptr   (arb_ptr)
    );

    // Presence pins are asynchronous to clk; bring them through a flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd4_sync <= '0;
            rd5_sync <= '0;
        end else begin
            rd4_sync[0] <= rd4;
            rd5_sync[0] <= rd5;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rd4_sync[i] <= rd4_sync[i-1];
                rd5_sync[i] <= rd5_sync[i-1];
            end
        end
    end

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        gnt_port_nxt  = gnt_port;
        ack_nxt       = 2'b00;
        err_nxt       = 1'b0;
        rd_data_nxt   = rd_data;
        cart_addr_nxt = cart_addr;
        s4_n_nxt      = s4_n;
        s5_n_nxt      = s5_n;
        arb_adv       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    arb_adv      = 1'b1;
                    gnt_port_nxt = gnt_idx;
                    cnt_nxt      = '0;
                    if ((sel_addr[15:13] == S4_HI) && rd4_ok) begin
                        state_nxt     = ST_SETUP;
                        cart_addr_nxt = sel_addr[12:0];
                        s4_n_nxt      = 1'b0;
                    end else if ((sel_addr[15:13] == S5_HI) && rd5_ok) begin
                        state_nxt     = ST_SETUP;
                        cart_addr_nxt = sel_addr[12:0];
                        s5_n_nxt      = 1'b0;
                    end else begin
                        // Outside both windows or no cartridge: answer at once
                        state_nxt        = ST_ERRACK;
                        ack_nxt[gnt_idx] = 1'b1;
                        err_nxt          = 1'b1;
                        rd_data_nxt      = EMPTY_BYTE;
                    end
                end
            end
            ST_SETUP: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    // Data capture edge: sample the bus and release the selects together
                    state_nxt         = ST_RECOVER;
                    cnt_nxt           = '0;
                    rd_data_nxt       = cart_data;
                    ack_nxt[gnt_port] = 1'b1;
                    s4_n_nxt          = 1'b1;
                    s5_n_nxt          = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_RECOVER: begin
                if (cnt == REC_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_ERRACK: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State and output registers; reset drops the selects without waiting for clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            gnt_port  <= 1'b0;
            ack       <= 2'b00;
            err       <= 1'b0;
            rd_data   <= EMPTY_BYTE;
            cart_addr <= '0;
            s4_n      <= 1'b1;
            s5_n      <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            gnt_port  <= gnt_port_nxt;
            ack       <= ack_nxt;
            err       <= err_nxt;
            rd_data   <= rd_data_nxt;
            cart_addr <= cart_addr_nxt;
            s4_n      <= s4_n_nxt;
            s5_n      <= s5_n_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Bench for cart_bus_arbiter: directed cases, randomized traffic, and a second
// instance with WAIT_CYCLES=1 / RECOVER_CYCLES=3.
// Expected outputs come from a cycle-count transaction model kept in this file.
module tb_cart_bus_arbiter;

    localparam int W  = 4;
    localparam int R  = 1;
    localparam int S  = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req   = 2'b00;
    logic [15:0] addr0 = 16'h0000;
    logic [15:0] addr1 = 16'h0000;
    logic        rd4   = 1'b0;
    logic        rd5   = 1'b0;
    logic [7:0]  cart_data = 8'h00;
    logic [1:0]  ack;
    logic        err;
    logic [7:0]  rd_data;
    logic        busy;
    logic [12:0] cart_addr;
    logic        s4_n, s5_n;

    logic [1:0]  req2   = 2'b00;
    logic [15:0] addr0_2 = 16'h0000;
    logic [15:0] addr1_2 = 16'h0000;
    logic        rd4_2  = 1'b1;
    logic        rd5_2  = 1'b1;
    logic [7:0]  cart_data2 = 8'h00;
    logic [1:0]  ack2;
    logic        err2;
    logic [7:0]  rd_data2;
    logic        busy2;
    logic [12:0] cart_addr2;
    logic        s4_n2, s5_n2;

    cart_bus_arbiter #(.WAIT_CYCLES(W), .RECOVER_CYCLES(R), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .addr0(addr0), .addr1(addr1),
        .ack(ack), .err(err), .rd_data(rd_data), .busy(busy),
        .rd4(rd4), .rd5(rd5), .cart_addr(cart_addr), .s4_n(s4_n), .s5_n(s5_n),
        .cart_data(cart_data)
    );

    cart_bus_arbiter #(.WAIT_CYCLES(1), .RECOVER_CYCLES(3), .SYNC_STAGES(S)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .addr0(addr0_2), .addr1(addr1_2),
        .ack(ack2), .err(err2), .rd_data(rd_data2), .busy(busy2),
        .rd4(rd4_2), .rd5(rd5_2), .cart_addr(cart_addr2), .s4_n(s4_n2), .s5_n(s5_n2),
        .cart_data(cart_data2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // A granted access is tracked only by how many cycles have passed since grant.
    logic [1:0]  e_ack;
    logic        e_err, e_busy, e_s4_n, e_s5_n;
    logic [7:0]  e_rd;
    logic [12:0] e_addr;
    logic        m_act;
    int          m_cyc, m_kind, m_port, m_ptr, mp;
    logic [15:0] ma;
    logic        h4 [S];
    logic        h5 [S];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_ack = 2'b00; e_err = 1'b0; e_busy = 1'b0; e_s4_n = 1'b1; e_s5_n = 1'b1;
            e_rd = 8'hFF; e_addr = 13'h0; m_act = 1'b0; m_cyc = 0; m_kind = 0;
            m_port = 0; m_ptr = 0;
            for (int i = 0; i < S; i++) begin h4[i] = 1'b0; h5[i] = 1'b0; end
        end else begin
            e_ack = 2'b00;
            e_err = 1'b0;
            if (m_act) begin
                m_cyc++;
                if (m_kind == 2) begin
                    if (m_cyc == 2) m_act = 1'b0;
                end else begin
                    if (m_cyc == 2 + W) begin
                        e_ack[m_port] = 1'b1;
                        e_rd   = cart_data;
                        e_s4_n = 1'b1;
                        e_s5_n = 1'b1;
                    end
                    if (m_cyc == 2 + W + R) m_act = 1'b0;
                end
            end else if (req != 2'b00) begin
                mp     = (req == 2'b11) ? m_ptr : (req[1] ? 1 : 0);
                m_ptr  = 1 - mp;
                m_port = mp;
                ma     = (mp == 1) ? addr1 : addr0;
                m_act  = 1'b1;
                m_cyc  = 1;
                if (ma[15:13] == 3'b100 && h4[S-1]) begin
                    m_kind = 0; e_addr = ma[12:0]; e_s4_n = 1'b0;
                end else if (ma[15:13] == 3'b101 && h5[S-1]) begin
                    m_kind = 1; e_addr = ma[12:0]; e_s5_n = 1'b0;
                end else begin
                    m_kind = 2; e_ack[mp] = 1'b1; e_err = 1'b1; e_rd = 8'hFF;
                end
            end
            e_busy = m_act;
            for (int i = S - 1; i > 0; i--) begin h4[i] = h4[i-1]; h5[i] = h5[i-1]; end
            h4[0] = rd4;
            h5[0] = rd5;
        end
    end

    // ---------------- per-cycle comparison ----------------
    int ack_log[$];

    always @(negedge clk) begin
        if (rst_n) begin
            check("ack", 32'(ack), 32'(e_ack));
            check("err", 32'(err), 32'(e_err));
            check("busy", 32'(busy), 32'(e_busy));
            check("s4_n", 32'(s4_n), 32'(e_s4_n));
            check("s5_n", 32'(s5_n), 32'(e_s5_n));
            check("cart_addr", 32'(cart_addr), 32'(e_addr));
            check("rd_data", 32'(rd_data), 32'(e_rd));
            check("sel_exclusive", 32'(s4_n | s5_n), 32'd1);
            if (ack[0]) ack_log.push_back(0);
            if (ack[1]) ack_log.push_back(1);
        end
    end

    // ---------------- random requester ----------------
    int mode = 0;  // 0 directed, 1 random traffic, 2 drain

    function automatic logic [15:0] rand_addr();
        logic [12:0] lo;
        lo = 13'($urandom);
        case ($urandom_range(0, 3))
            0:       return {3'b100, lo};
            1:       return {3'b101, lo};
            default: return 16'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (mode != 0) begin
            for (int p = 0; p < 2; p++) begin
                if (req[p] && e_ack[p]) begin
                    if (mode == 1 && $urandom_range(0, 1) == 1) begin
                        if (p == 0) addr0 = rand_addr(); else addr1 = rand_addr();
                    end else begin
                        req[p] = 1'b0;
                    end
                end else if (!req[p] && mode == 1 && $urandom_range(0, 3) == 0) begin
                    if (p == 0) addr0 = rand_addr(); else addr1 = rand_addr();
                    req[p] = 1'b1;
                end
            end
            if (mode == 1) begin
                cart_data = 8'($urandom);
                if ($urandom_range(0, 31) == 0) rd4 = ~rd4;
                if ($urandom_range(0, 31) == 0) rd5 = ~rd5;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int nacks;
        int drained;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst ack", 32'(ack), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst rd_data", 32'(rd_data), 32'hFF);
        check("rst cart_addr", 32'(cart_addr), 32'd0);
        check("rst s4_n", 32'(s4_n), 32'd1);
        check("rst s5_n", 32'(s5_n), 32'd1);
        rst_n = 1'b1;

        // Single S4 read
        rd4 = 1'b1; rd5 = 1'b1;
        repeat (S + 1) @(negedge clk);
        addr0 = 16'h8123; cart_data = 8'h5A;
        req = 2'b01;
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k <= 5) check("s4 single low", 32'(s4_n), 32'd0);
            check("s5 single high", 32'(s5_n), 32'd1);
            if (k == 1) check("s4 single addr", 32'(cart_addr), 32'h0123);
            if (k == 6) begin
                check("s4 single ack", 32'(ack), 32'b01);
                check("s4 single data", 32'(rd_data), 32'h5A);
                check("s4 single release", 32'(s4_n), 32'd1);
                req = 2'b00;
            end
            if (k == 7) check("s4 single idle", 32'(busy), 32'd0);
        end

        // S5 read from port 1
        @(negedge clk);
        addr1 = 16'hBFFF; cart_data = 8'hC3;
        req = 2'b10;
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check("s5 read s4 high", 32'(s4_n), 32'd1);
            if (k == 1) begin
                check("s5 read low", 32'(s5_n), 32'd0);
                check("s5 read addr", 32'(cart_addr), 32'h1FFF);
            end
            if (k == 6) begin
                check("s5 read ack", 32'(ack), 32'b10);
                check("s5 read data", 32'(rd_data), 32'hC3);
                check("s5 read err", 32'(err), 32'd0);
                req = 2'b00;
            end
        end

        // Contention: both held for four accesses
        @(negedge clk);
        ack_log.delete();
        addr0 = 16'h8000; addr1 = 16'hA000;
        req = 2'b11;
        nacks = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (e_ack != 2'b00) nacks++;
            if (nacks == 4) begin
                req = 2'b00;
                break;
            end
        end
        repeat (4) @(negedge clk);
        check("contention ack count", 32'(ack_log.size()), 32'd4);
        if (ack_log.size() == 4) begin
            check("contention order 0", 32'(ack_log[0]), 32'd0);
            check("contention order 1", 32'(ack_log[1]), 32'd1);
            check("contention order 2", 32'(ack_log[2]), 32'd0);
            check("contention order 3", 32'(ack_log[3]), 32'd1);
        end

        // Error path: outside both windows, then S4 with no cartridge
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            if (t == 0) begin
                addr0 = 16'h4000;
            end else begin
                rd4 = 1'b0;
                repeat (S + 1) @(negedge clk);
                addr0 = 16'h8000;
            end
            req = 2'b01;
            @(posedge clk);
            @(negedge clk);
            check("err ack", 32'(ack), 32'b01);
            check("err flag", 32'(err), 32'd1);
            check("err data", 32'(rd_data), 32'hFF);
            check("err s4_n", 32'(s4_n), 32'd1);
            check("err s5_n", 32'(s5_n), 32'd1);
            req = 2'b00;
            @(negedge clk);
            check("err ack clear", 32'(ack), 32'd0);
            check("err back idle", 32'(busy), 32'd0);
        end

        // Randomized traffic
        mode = 1;
        repeat (3000) @(negedge clk);
        mode = 2;
        drained = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (req == 2'b00 && !e_busy) begin
                drained = 1;
                break;
            end
        end
        check("random drain", 32'(drained), 32'd1);
        mode = 0;
        req = 2'b00;

        // Reset in the middle of a WAIT phase
        rd4 = 1'b1; rd5 = 1'b1;
        repeat (S + 1) @(negedge clk);
        addr0 = 16'h8456; cart_data = 8'h3C;
        req = 2'b01;
        @(posedge clk);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        req = 2'b00;
        #1;
        check("midreset s4_n", 32'(s4_n), 32'd1);
        check("midreset ack", 32'(ack), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        check("midreset no ack", 32'(ack), 32'd0);
        rst_n = 1'b1;
        repeat (S + 1) @(negedge clk);
        check("post reset idle", 32'(busy), 32'd0);
        req = 2'b01;
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) check("post reset select", 32'(s4_n), 32'd0);
            if (k == 6) begin
                check("post reset ack", 32'(ack), 32'b01);
                check("post reset data", 32'(rd_data), 32'h3C);
                req = 2'b00;
            end
        end

        // Second instance: WAIT_CYCLES=1, RECOVER_CYCLES=3, request held across two accesses
        @(negedge clk);
        addr0_2 = 16'h8010; cart_data2 = 8'h77;
        req2 = 2'b01;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k <= 2) check("sweep select low", 32'(s4_n2), 32'd0);
            if (k == 1) check("sweep addr", 32'(cart_addr2), 32'h0010);
            if (k == 2) check("sweep no early ack", 32'(ack2), 32'd0);
            if (k == 3) begin
                check("sweep ack", 32'(ack2), 32'b01);
                check("sweep data", 32'(rd_data2), 32'h77);
            end
            if (k >= 3 && k <= 5) begin
                check("sweep recover high", 32'(s4_n2), 32'd1);
                check("sweep recover busy", 32'(busy2), 32'd1);
            end
            if (k == 4) check("sweep ack single", 32'(ack2), 32'd0);
            if (k == 6) check("sweep idle", 32'(busy2), 32'd0);
            if (k == 7) begin
                check("sweep next setup", 32'(s4_n2), 32'd0);
                req2 = 2'b00;
            end
            if (k == 8) check("sweep s5 high", 32'(s5_n2), 32'd1);
        end
        repeat (10) @(negedge clk);
        check("sweep final idle", 32'(busy2), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
